// File: rtl/irq_arb_pkg.sv
// Shared types and limits for the interrupt arbiter.
package irq_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SERV} irq_arb_state_t;

  localparam int IRQ_ARB_MAX_SRC = 32;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational picker: first set bit of req, searching upward from start
// and wrapping modulo N_SRC. start = 0 gives plain lowest-index priority.
module irq_prio_sel
  import irq_arb_pkg::*;
#(
  parameter  int N_SRC = 8,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Walk from the farthest offset back to start so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[(int'(start) + i) % N_SRC]) begin
        valid = 1'b1;
        id    = ID_W'((int'(start) + i) % N_SRC);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Shares one CPU interrupt line between N_SRC edge-triggered sources.
// Rising edges set pending bits; one unmasked pending source is presented
// to the controller and held until mret, then acked and cleared.
// Optional feature macro: IRQ_ARB_ROUND_ROBIN_EN (round-robin instead of
// fixed lowest-index priority).
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter  int N_SRC = 8,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             irq_taken_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0] irq_ack_o,
  output logic [N_SRC-1:0] pending_o
);

  if (N_SRC < 2 || N_SRC > IRQ_ARB_MAX_SRC) begin : g_bad_n_src
    $error("irq_arbiter: N_SRC out of range");
  end

  irq_arb_state_t   state_q;
  logic [N_SRC-1:0] src_q, pending_q, rise, clr, sel_req;
  logic [ID_W-1:0]  id_q, start, sel_id;
  logic             sel_valid, req_q, ret_fire;

  assign rise     = irq_src_i & ~src_q;
  assign sel_req  = pending_q & irq_mask_i;
  assign ret_fire = (state_q == SERV) && irq_ret_i;

  // One-hot clear of the serviced source, only on a real return.
  always_comb begin
    clr = '0;
    if (ret_fire) clr[id_q] = 1'b1;
  end

  // Edge history and pending bits; a fresh edge beats a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q     <= '0;
      pending_q <= '0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_q;

  // Remember the last serviced source; reset value makes source 0 first.
  always_ff @(posedge clk_i) begin
    if (rst_i)         last_q <= ID_W'(N_SRC - 1);
    else if (ret_fire) last_q <= id_q;
  end

  assign start = (last_q == ID_W'(N_SRC - 1)) ? '0 : last_q + ID_W'(1);
`else
  assign start = '0;
`endif

  irq_prio_sel #(.N_SRC(N_SRC)) u_sel (
    .req   (sel_req),
    .start (start),
    .valid (sel_valid),
    .id    (sel_id)
  );

  // Request handshake: pick in IDLE, hold ID through REQ and SERV.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sel_valid) begin
          id_q    <= sel_id;
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (irq_taken_i) begin
          req_q   <= 1'b0;
          state_q <= SERV;
        end
        SERV: if (irq_ret_i) state_q <= IDLE;
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq_req_o = req_q;
  assign irq_id_o  = (state_q == IDLE) ? '0 : id_q;
  // Ack follows the return in the same cycle; a reset in that cycle suppresses it.
  assign irq_ack_o = rst_i ? '0 : clr;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Randomised scoreboard bench for irq_arbiter (N_SRC = 8).
module tb_irq_arbiter;
  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] irq_src_i = '0;
  logic [N-1:0] irq_mask_i = '0;
  logic         irq_taken_i = 1'b0;
  logic         irq_ret_i = 1'b0;
  logic         irq_req_o;
  logic [2:0]   irq_id_o;
  logic [N-1:0] irq_ack_o;
  logic [N-1:0] pending_o;

  irq_arbiter #(.N_SRC(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_src_i   (irq_src_i),
    .irq_mask_i  (irq_mask_i),
    .irq_taken_i (irq_taken_i),
    .irq_ret_i   (irq_ret_i),
    .irq_req_o   (irq_req_o),
    .irq_id_o    (irq_id_o),
    .irq_ack_o   (irq_ack_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference state: set of pending sources, last driven source levels,
  // and the most recently serviced ID (fixed priority keeps it at N-1).
  bit [N-1:0] m_pend = '0;
  bit [N-1:0] m_prev = '0;
  int         m_last = N - 1;

  int         idq[$];
  bit [N-1:0] ackq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Winner = first pending-and-enabled source after 'last', wrapping.
  function automatic int pick(input bit [N-1:0] p, input int last);
    for (int i = 1; i <= N; i++) begin
      int idx = (last + i) % N;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit [N-1:0] rnd_src();
    return 8'($urandom & $urandom & $urandom) & ~m_prev;
  endfunction

  // One clock: drive at negedge, update the model for the coming edge.
  task automatic step(input bit [N-1:0] src, input bit tk, input bit rt,
                      input bit [N-1:0] clr, input bit rs);
    @(negedge clk_i);
    irq_src_i   = src;
    irq_taken_i = tk;
    irq_ret_i   = rt;
    rst_i       = rs;
    if (rs) begin
      m_pend = '0;
      m_prev = '0;
      m_last = N - 1;
      idq.delete();
      ackq.delete();
    end else begin
      m_pend = (m_pend & ~clr) | (src & ~m_prev);
      m_prev = src;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, int'(irq_req_o), 0);
    chk({tag, "_id"}, int'(irq_id_o), 0);
    chk({tag, "_ack"}, int'(irq_ack_o), 0);
    chk({tag, "_pending"}, int'(pending_o), 0);
  endtask

  // Full service of the next winner. The DUT is idle with an enabled
  // pending source that it will register on the very next edge.
  task automatic run_service(input bit rnd, input bit rerise, input bit rst_serv);
    int         exp;
    int         n;
    bit [N-1:0] s;
    exp = pick(m_pend & irq_mask_i, m_last);
    idq.push_back(exp);
    n = 0;
    while (!irq_req_o && n < 4) begin
      step('0, 0, 0, '0, 0);
      n++;
    end
    chk("req_latency", irq_req_o ? n : 99, 1);
    if (!irq_req_o) begin
      step('0, 0, 0, '0, 1);
      return;
    end
    // REQ: mask changes and stray mret must not disturb the held ID
    repeat (rnd ? $urandom_range(0, 2) : 1) begin
      if (rnd && $urandom_range(0, 3) == 0) irq_mask_i = 8'($urandom | $urandom);
      step(rnd ? rnd_src() : '0, 0, rnd && $urandom_range(0, 3) == 0, '0, 0);
    end
    chk("id_held_req", int'(irq_id_o), exp);
    step(rnd ? rnd_src() : '0, 1, 0, '0, 0);
    chk("req_drop_serv", int'(irq_req_o), 0);
    chk("id_serv", int'(irq_id_o), exp);
    // SERV: stray taken is ignored
    repeat (rnd ? $urandom_range(0, 3) : 1)
      step(rnd ? rnd_src() : '0, rnd && $urandom_range(0, 3) == 0, 0, '0, 0);
    if (rst_serv) begin
      step('0, 0, 1, '0, 1);
      check_reset_outputs("rst_serv");
      return;
    end
    s = rnd ? rnd_src() : '0;
    if ((rerise || (rnd && $urandom_range(0, 2) == 0)) && !m_prev[exp]) s[exp] = 1'b1;
    ackq.push_back(8'(1 << exp));
    step(s, 0, 1, 8'(1 << exp), 0);
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    m_last = exp;
`endif
    chk("req_after_ret", int'(irq_req_o), 0);
    chk("pending_after_ret", int'(pending_o), int'(m_pend));
  endtask

  // Monitor: compares the ID on each new request and every ack pulse.
  bit         req_prev = 1'b0;
  int         mon_id;
  bit [N-1:0] mon_ack;
  always @(negedge clk_i) begin
    #2;
    if (irq_req_o && !req_prev) begin
      if (idq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: id=%0d with no request expected", irq_id_o);
      end else begin
        mon_id = idq.pop_front();
        chk("req_id", int'(irq_id_o), mon_id);
      end
    end
    if (irq_ack_o != '0) begin
      if (ackq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack=%0h with no ack expected", irq_ack_o);
      end else begin
        mon_ack = ackq.pop_front();
        chk("ack", int'(irq_ack_o), int'(mon_ack));
      end
    end
    req_prev = irq_req_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [N-1:0] s;
    step('0, 0, 0, '0, 1);
    step('0, 0, 0, '0, 1);
    check_reset_outputs("reset");

    // single source 3
    irq_mask_i = 8'hFF;
    step(8'h08, 0, 0, '0, 0);
    run_service(0, 0, 0);
    chk("t1_pending_clear", int'(pending_o), 0);

    // sources 2 and 5 together
    step(8'h24, 0, 0, '0, 0);
    run_service(0, 0, 0);
    run_service(0, 0, 0);

    // masked source 4 latches but is not requested
    irq_mask_i = 8'hEF;
    step(8'h10, 0, 0, '0, 0);
    repeat (3) step('0, 0, 0, '0, 0);
    chk("masked_no_req", int'(irq_req_o), 0);
    chk("masked_pending4", int'(pending_o[4]), 1);
    irq_mask_i = 8'hFF;
    run_service(0, 0, 0);

    // source 6 re-rises in its own return cycle
    step(8'h40, 0, 0, '0, 0);
    run_service(0, 1, 0);
    chk("rerise_pending6", int'(pending_o[6]), 1);
    run_service(0, 0, 0);

    // sources 0 and 1 keep re-firing
    step(8'h03, 0, 0, '0, 0);
    repeat (4) run_service(0, 1, 0);
    while ((m_pend & irq_mask_i) != 0) run_service(0, 0, 0);

    // reset while in service
    step(8'h20, 0, 0, '0, 0);
    run_service(0, 0, 1);

    // randomised traffic
    repeat (300) begin
      if ((m_pend & irq_mask_i) != 0) begin
        run_service(1, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
      end else if ($urandom_range(0, 3) == 0) begin
        irq_mask_i = 8'($urandom | $urandom);
      end else begin
        s = rnd_src();
        if (s == 0) s = 8'(1 << $urandom_range(0, N - 1)) & ~m_prev;
        step(s, 0, 0, '0, 0);
        if ((m_pend & irq_mask_i) == 0) begin
          step('0, 0, 0, '0, 0);
          chk("idle_no_req", int'(irq_req_o), 0);
          chk("idle_pending", int'(pending_o), int'(m_pend));
        end
      end
    end
    while ((m_pend & irq_mask_i) != 0) run_service(1, 0, 0);

    repeat (3) step('0, 0, 0, '0, 0);
    chk("idq_drained", idq.size(), 0);
    chk("ackq_drained", ackq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
